// File: rtl/pipe_controller.sv
// Pipeline stage-enable controller: data-memory access FSM plus control-flow bubble counter.
// Outputs are combinational from registered state; memory stall outranks bubble, which outranks fetch stall.
module pipe_controller #(
   parameter int BUBBLE_CYCLES = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        complete_instr,
   input  logic        complete_data,
   input  logic [15:0] ir,
   input  logic [15:0] ir_exec,
   input  logic [2:0]  psr,
   output logic        enable_updatePC,
   output logic        enable_fetch,
   output logic        enable_decode,
   output logic        enable_execute,
   output logic        enable_writeback,
   output logic        br_taken,
   output logic [1:0]  mem_state
);

   typedef enum logic [1:0] {
      S_READ     = 2'd0,
      S_INDIRECT = 2'd1,
      S_WRITE    = 2'd2,
      S_IDLE     = 2'd3
   } mem_st_t;

   localparam logic [1:0] BUB_LOAD = 2'(BUBBLE_CYCLES);

   mem_st_t    r_state;
   logic       r_is_store;
   logic [1:0] r_cnt;
   logic       r_is_jmp;
   logic [2:0] r_nzp;

   logic [3:0] w_opx;
   logic [3:0] w_op;
   logic       w_is_ld;
   logic       w_is_st;
   logic       w_is_ind;
   logic       w_is_ctrl;
   logic       w_stall;
   logic       w_bubble;
   logic       w_br;
   logic [4:0] w_en;
   logic       w_unused_bits;

   assign w_opx     = ir_exec[15:12];
   assign w_op      = ir[15:12];
   assign w_is_ld   = (w_opx == 4'b0010) || (w_opx == 4'b0110);
   assign w_is_st   = (w_opx == 4'b0011) || (w_opx == 4'b0111);
   assign w_is_ind  = (w_opx == 4'b1010) || (w_opx == 4'b1011);
   assign w_is_ctrl = (w_op == 4'b0000) || (w_op == 4'b1100);
   assign w_stall   = (r_state != S_IDLE);
   assign w_bubble  = (r_cnt != 2'd0);
   // psr is sampled live in the redirect cycle; only opcode and nzp are latched
   assign w_br      = reset && !w_stall && (r_cnt == 2'd1) && (r_is_jmp || |(r_nzp & psr));

   // Operand fields are not needed for control decisions
   assign w_unused_bits = &{1'b0, ir[8:0], ir_exec[11:0]};

   // w_en = {updatePC, fetch, decode, execute, writeback}
   always_comb begin
      w_en = 5'b11111;
      if (!reset || w_stall)
         w_en = 5'b00000;
      else if (w_bubble)
         w_en = {w_br, 4'b0111};
      else if (!complete_instr)
         w_en = 5'b00011;
   end

   assign {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback} = w_en;
   assign br_taken  = w_br;
   assign mem_state = r_state;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_is_store <= 1'b0;
         r_cnt      <= 2'd0;
         r_is_jmp   <= 1'b0;
         r_nzp      <= 3'b000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_en[1] && (w_is_ld || w_is_st || w_is_ind)) begin
                  r_is_store <= w_opx[0];
                  if (w_is_ind)
                     r_state <= S_INDIRECT;
                  else if (w_is_st)
                     r_state <= S_WRITE;
                  else
                     r_state <= S_READ;
               end
            end
            S_INDIRECT: begin
               if (complete_data)
                  r_state <= r_is_store ? S_WRITE : S_READ;
            end
            S_READ, S_WRITE: begin
               if (complete_data)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // A control op seen mid-bubble is ignored; the counter only reloads from zero
         if (w_bubble) begin
            if (!w_stall)
               r_cnt <= r_cnt - 2'd1;
         end else if (w_en[2] && w_is_ctrl) begin
            r_cnt    <= BUB_LOAD;
            r_is_jmp <= (w_op == 4'b1100);
            r_nzp    <= ir[11:9];
         end
      end
   end

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: per-cycle vector table plus hand-written reset sequences,
// expected outputs queued when each cycle is driven and popped when outputs settle.
module tb_pipe_controller;

   localparam logic [15:0] ADD  = 16'h1000;
   localparam logic [15:0] LD   = 16'h2000;
   localparam logic [15:0] LDR  = 16'h6000;
   localparam logic [15:0] LDI  = 16'hA000;
   localparam logic [15:0] STI  = 16'hB000;
   localparam logic [15:0] BR2  = 16'h0400;
   localparam logic [15:0] BR4  = 16'h0800;
   localparam logic [15:0] JMP  = 16'hC000;

   typedef struct {
      logic        rst;
      logic        ci;
      logic        cd;
      logic [15:0] ir;
      logic [15:0] irx;
      logic [2:0]  psr;
      logic [1:0]  ms;
      logic [4:0]  en;
      logic        br;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        complete_instr = 1'b1;
   logic        complete_data = 1'b0;
   logic [15:0] ir = ADD;
   logic [15:0] ir_exec = ADD;
   logic [2:0]  psr = 3'b000;
   logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
   logic        br_taken;
   logic [1:0]  mem_state;

   int total = 0;
   int bad   = 0;
   int row   = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   pipe_controller #(.BUBBLE_CYCLES(3)) dut (
      .clock           (clock),
      .reset           (reset),
      .complete_instr  (complete_instr),
      .complete_data   (complete_data),
      .ir              (ir),
      .ir_exec         (ir_exec),
      .psr             (psr),
      .enable_updatePC (enable_updatePC),
      .enable_fetch    (enable_fetch),
      .enable_decode   (enable_decode),
      .enable_execute  (enable_execute),
      .enable_writeback(enable_writeback),
      .br_taken        (br_taken),
      .mem_state       (mem_state)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input logic rst, input logic ci, input logic cd,
                               input logic [15:0] i_ir, input logic [15:0] i_irx,
                               input logic [2:0] i_psr, input logic [1:0] ms,
                               input logic [4:0] en, input logic br);
      vec_t v;
      v.rst = rst; v.ci = ci; v.cd = cd; v.ir = i_ir; v.irx = i_irx;
      v.psr = i_psr; v.ms = ms; v.en = en; v.br = br;
      return v;
   endfunction

   task automatic check_out();
      vec_t e;
      logic [4:0] got_en;
      e = exp_q.pop_front();
      got_en = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
      total++;
      if (mem_state !== e.ms || got_en !== e.en || br_taken !== e.br) begin
         bad++;
         $display("FAIL cycle%0d: mem_state=%0d en=%b br=%b, expected mem_state=%0d en=%b br=%b",
                  row, mem_state, got_en, br_taken, e.ms, e.en, e.br);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and check the settled outputs
   task automatic apply(input vec_t v);
      @(negedge clock);
      reset = v.rst; complete_instr = v.ci; complete_data = v.cd;
      ir = v.ir; ir_exec = v.irx; psr = v.psr;
      exp_q.push_back(v);
      #2;
      check_out();
      row++;
   endtask

   initial begin
      // Reset state, then first cycle after release
      vecs.push_back(mk(0,1,0,ADD,ADD,3'b000,2'd3,5'b00000,0));
      vecs.push_back(mk(0,1,0,ADD,ADD,3'b000,2'd3,5'b00000,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd3,5'b11111,0));
      // Fetch stall; a control op there is not decoded so no bubble follows
      vecs.push_back(mk(1,0,0,ADD,ADD,3'b000,2'd3,5'b00011,0));
      vecs.push_back(mk(1,0,0,BR2,ADD,3'b010,2'd3,5'b00011,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b010,2'd3,5'b11111,0));
      // LDR: 3,0,0,0,3
      vecs.push_back(mk(1,1,0,ADD,LDR,3'b000,2'd3,5'b11111,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd0,5'b00000,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd0,5'b00000,0));
      vecs.push_back(mk(1,1,1,ADD,ADD,3'b000,2'd0,5'b00000,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd3,5'b11111,0));
      // STI: 1,1,2,2,3 with no READ
      vecs.push_back(mk(1,1,0,ADD,STI,3'b000,2'd3,5'b11111,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd1,5'b00000,0));
      vecs.push_back(mk(1,1,1,ADD,ADD,3'b000,2'd1,5'b00000,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd2,5'b00000,0));
      vecs.push_back(mk(1,1,1,ADD,ADD,3'b000,2'd2,5'b00000,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd3,5'b11111,0));
      // BR nzp=010, psr=010: taken in third bubble cycle
      vecs.push_back(mk(1,1,0,BR2,ADD,3'b010,2'd3,5'b11111,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b010,2'd3,5'b00111,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b010,2'd3,5'b00111,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b010,2'd3,5'b10111,1));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b010,2'd3,5'b11111,0));
      // BR nzp=100, psr=001: not taken; JMP in decode mid-bubble is ignored
      vecs.push_back(mk(1,1,0,BR4,ADD,3'b001,2'd3,5'b11111,0));
      vecs.push_back(mk(1,1,0,JMP,ADD,3'b001,2'd3,5'b00111,0));
      vecs.push_back(mk(1,1,0,JMP,ADD,3'b001,2'd3,5'b00111,0));
      vecs.push_back(mk(1,1,0,JMP,ADD,3'b001,2'd3,5'b00111,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b001,2'd3,5'b11111,0));
      // JMP bubble with LD entering at counter=2: frozen through stall
      vecs.push_back(mk(1,1,0,JMP,ADD,3'b000,2'd3,5'b11111,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd3,5'b00111,0));
      vecs.push_back(mk(1,1,0,ADD,LD, 3'b000,2'd3,5'b00111,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd0,5'b00000,0));
      vecs.push_back(mk(1,1,1,ADD,ADD,3'b000,2'd0,5'b00000,0));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd3,5'b10111,1));
      vecs.push_back(mk(1,1,0,ADD,ADD,3'b000,2'd3,5'b11111,0));

      @(posedge clock);
      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i]);

      // Reset during INDIRECT abandons the access
      apply(mk(1,1,0,ADD,LDI,3'b000,2'd3,5'b11111,0));
      apply(mk(0,1,0,ADD,ADD,3'b000,2'd1,5'b00000,0));
      apply(mk(0,1,0,ADD,ADD,3'b000,2'd3,5'b00000,0));
      apply(mk(1,1,0,ADD,ADD,3'b000,2'd3,5'b11111,0));
      // Reset mid-bubble clears the counter so no redirect follows
      apply(mk(1,1,0,BR2,ADD,3'b010,2'd3,5'b11111,0));
      apply(mk(1,1,0,ADD,ADD,3'b010,2'd3,5'b00111,0));
      apply(mk(0,1,0,ADD,ADD,3'b010,2'd3,5'b00000,0));
      apply(mk(1,1,0,ADD,ADD,3'b010,2'd3,5'b11111,0));
      apply(mk(1,1,0,ADD,ADD,3'b010,2'd3,5'b11111,0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have parameter BUBBLE_CYCLES, default 3, meaning fetch-suppression cycles after a control instruction is decoded (legal 1..3).
REQ-002 SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset sampled on the rising edge of clock.
REQ-004 SHALL have port complete_instr, input, 1, instruction memory read finished this cycle.
REQ-005 SHALL have port complete_data, input, 1, data memory access finished this cycle.
REQ-006 SHALL have port ir, input, 16, instruction held in the decode output register.
REQ-007 SHALL have port ir_exec, input, 16, instruction held in the execute stage.
REQ-008 SHALL have port psr, input, 3, current N/Z/P condition codes.
REQ-009 SHALL have port enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback, output, 1 each, per-stage advance enables.
REQ-010 SHALL have port br_taken, output, 1, redirect PC to the computed target.
REQ-011 SHALL have port mem_state, output, 2, data memory FSM state: 0 READ, 1 INDIRECT, 2 WRITE, 3 IDLE.

Function
REQ-012 SHALL classify opcode = ir_exec[15:12] as memory ops: LD 0010, LDR 0110, LDI 1010, ST 0011, STR 0111, STI 1011.
REQ-013 SHALL classify opcode = ir[15:12] as control ops: BR 0000, JMP 1100.
REQ-014 SHALL run the memory FSM with these transitions:
- IDLE -> READ on LD/LDR.
- IDLE -> WRITE on ST/STR.
- IDLE -> INDIRECT on LDI/STI.
- The IDLE exit is taken only in a cycle where enable_execute=1.
REQ-015 SHALL leave INDIRECT on complete_data=1 to READ for LDI or WRITE for STI, using a registered is_store flag captured at IDLE exit.
REQ-016 SHALL return READ and WRITE to IDLE on complete_data=1, and hold the state while complete_data=0.
REQ-017 SHALL drive mem_state combinationally from the current FSM state register, with no added latency.
REQ-018 SHALL force all five enables to 0 while mem_state != 3 (memory stall).
REQ-019 SHALL, when the decode stage advances (enable_decode=1) with a control op in ir, load a bubble counter with BUBBLE_CYCLES on the next edge.
REQ-020 SHALL, while the bubble counter > 0 and no memory stall, drive enable_updatePC=0 and enable_fetch=0, keep the other enables at 1, and decrement the counter by 1 per cycle.
REQ-021 SHALL assert br_taken for exactly the one cycle in which the bubble counter == 1, when the latched control instruction is JMP, or is BR with |(ir[11:9] & psr).
REQ-022 SHALL, in the br_taken cycle, force enable_updatePC=1 so the PC loads the target.
REQ-023 SHALL latch the control instruction's opcode and nzp at counter load, so later decode contents do not affect br_taken.
REQ-024 SHALL give memory stall priority over bubble: during a memory stall the counter freezes and br_taken=0; br_taken resumes after the stall.
REQ-025 SHALL ignore a new control op while the counter > 0, so counter reload cannot occur mid-bubble.
REQ-026 SHALL, when complete_instr=0 and no other stall, drive enable_updatePC, enable_fetch and enable_decode to 0, and leave enable_execute and enable_writeback at 1.
REQ-027 SHALL, when no stall and no bubble, drive all enables to 1 and br_taken=0.

Reset
REQ-028 SHALL, while reset=0 at a clock edge, set the memory FSM to IDLE (mem_state=3), bubble counter=0, is_store=0, br_taken=0 and all enables=0.
REQ-029 SHALL apply reset asserted mid-access or mid-bubble on the next edge, abandoning the access; no transaction state persists.
REQ-030 SHALL drive all enables to 1 in the first cycle after reset returns to 1, provided complete_instr=1.

Verification
REQ-031 SHALL pass: ir_exec=LDR with enable_execute=1, complete_data after 2 cycles -> mem_state 3,0,0,0,3; enables 0 for 3 cycles.
REQ-032 SHALL pass: ir_exec=STI, complete_data pulses at cycles 2 and 4 -> mem_state sequence 1,1,2,2,3; no READ visited.
REQ-033 SHALL pass: ir=BR nzp=010, psr=010 -> enable_fetch=0 for 3 cycles; br_taken=1 in the third cycle only; enable_updatePC=1 that cycle.
REQ-034 SHALL pass: ir=BR nzp=100, psr=001 -> 3-cycle bubble, br_taken never asserted.
REQ-035 SHALL pass: JMP bubble with LD reaching execute at counter=2 -> counter frozen through the memory stall, br_taken asserted one cycle after the stall clears.
REQ-036 SHALL pass: reset=0 during INDIRECT -> next cycle mem_state=3, enables 0, br_taken 0.
